// File: rtl/mem_mux_pkg.sv
// Shared types for the wide/narrow memory multiplexer: bus structs, AMO encoding,
// the wide read tag carried down the latency pipeline and index-width helpers.
package mem_mux_pkg;

    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned NarrowDataW = 32;
    localparam int unsigned WideDataW   = 512;
    localparam int unsigned MaxWideIdxW = 4;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2
    } amo_op_e;

    typedef struct packed {
        logic [AddrWidth-1:0]     addr;
        logic                     write;
        amo_op_e                  amo;
        logic [NarrowDataW-1:0]   data;
        logic [NarrowDataW/8-1:0] strb;
        logic                     user;
    } narrow_q_t;

    typedef struct packed {
        narrow_q_t q;
        logic      q_valid;
    } narrow_req_t;

    typedef struct packed {
        logic [NarrowDataW-1:0] data;
    } narrow_p_t;

    typedef struct packed {
        narrow_p_t p;
        logic      q_ready;
    } narrow_rsp_t;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   write;
        logic [WideDataW-1:0]   data;
        logic [WideDataW/8-1:0] strb;
        logic                   user;
    } wide_q_t;

    typedef struct packed {
        wide_q_t q;
        logic    q_valid;
    } wide_req_t;

    typedef struct packed {
        logic [WideDataW-1:0] data;
    } wide_p_t;

    typedef struct packed {
        wide_p_t p;
        logic    q_ready;
    } wide_rsp_t;

    typedef struct packed {
        logic                   valid;
        logic                   rd;
        logic [MaxWideIdxW-1:0] idx;
    } wide_tag_t;

endpackage

// File: rtl/mem_mux_starve_cnt.sv
// Per-bank starvation counter: counts cycles a narrow request loses to a wide issue
// and raises preempt once the limit is reached, until the narrow request completes.
module mem_mux_starve_cnt
    import mem_mux_pkg::*;
#(
    parameter int unsigned StarveLimit = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic narrow_valid_i,
    input  logic narrow_ready_i,
    input  logic wide_issue_i,
    output logic preempt_o
);

    localparam int unsigned CntW = idx_width(StarveLimit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (narrow_valid_i) begin
            if (narrow_ready_i) begin
                cnt_q <= '0;
            end else if (wide_issue_i && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign preempt_o = (StarveLimit != 0) && (cnt_q == CntMax);

endmodule

// File: rtl/mem_multi_wide_narrow_mux.sv
// Round-robin multiplexer of several wide masters and per-bank narrow masters onto
// narrow banks; wide requests hit all banks in one cycle, reads tagged through a latency pipe.
module mem_multi_wide_narrow_mux
    import mem_mux_pkg::*;
#(
    parameter int unsigned NarrowDataWidth = 32,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned NrWidePorts     = 2,
    parameter int unsigned MemoryLatency   = 1,
    parameter int unsigned StarveLimit     = 8,
    parameter type mem_narrow_req_t = narrow_req_t,
    parameter type mem_narrow_rsp_t = narrow_rsp_t,
    parameter type mem_wide_req_t   = wide_req_t,
    parameter type mem_wide_rsp_t   = wide_rsp_t,
    parameter int unsigned NrPorts = WideDataWidth / NarrowDataWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  mem_narrow_req_t        in_narrow_req_i [NrPorts],
    output mem_narrow_rsp_t        in_narrow_rsp_o [NrPorts],
    input  mem_wide_req_t          in_wide_req_i   [NrWidePorts],
    output mem_wide_rsp_t          in_wide_rsp_o   [NrWidePorts],
    output logic [NrWidePorts-1:0] wide_p_valid_o,
    output mem_narrow_req_t        out_req_o       [NrPorts],
    input  mem_narrow_rsp_t        out_rsp_i       [NrPorts]
);

    localparam int unsigned IdxW  = idx_width(NrWidePorts);
    localparam int unsigned ScanW = IdxW + 1;
    localparam int unsigned StrbW = NarrowDataWidth / 8;

    logic [IdxW-1:0]    rr_q, win;
    logic [ScanW-1:0]   scan;
    logic               found, all_ready, any_preempt, issue;
    logic [NrPorts-1:0] preempt, narrow_valid, narrow_ready;
    wide_tag_t          tag_q [MemoryLatency];
    wide_tag_t          tag_last;

    // Scan wide ports starting at the round-robin pointer, wrapping at NrWidePorts.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < int'(NrWidePorts); k++) begin
            scan = {1'b0, rr_q} + ScanW'(k);
            if (scan >= ScanW'(NrWidePorts)) scan = scan - ScanW'(NrWidePorts);
            if (!found && in_wide_req_i[scan[IdxW-1:0]].q_valid) begin
                found = 1'b1;
                win   = scan[IdxW-1:0];
            end
        end
    end

    always_comb begin
        all_ready = 1'b1;
        for (int i = 0; i < int'(NrPorts); i++) all_ready &= out_rsp_i[i].q_ready;
    end

    assign any_preempt = |preempt;
    assign issue       = !rst_i && found && all_ready && !any_preempt;

    always_comb begin
        for (int i = 0; i < int'(NrPorts); i++) begin
            out_req_o[i]               = in_narrow_req_i[i];
            out_req_o[i].q_valid       = in_narrow_req_i[i].q_valid && !rst_i;
            in_narrow_rsp_o[i]         = out_rsp_i[i];
            in_narrow_rsp_o[i].q_ready = out_rsp_i[i].q_ready && !issue && !rst_i;
            if (issue) begin
                out_req_o[i].q_valid = 1'b1;
                out_req_o[i].q.addr  = in_wide_req_i[win].q.addr;
                out_req_o[i].q.write = in_wide_req_i[win].q.write;
                out_req_o[i].q.user  = in_wide_req_i[win].q.user;
                out_req_o[i].q.amo   = AMONone;
                out_req_o[i].q.data  = in_wide_req_i[win].q.data[i*NarrowDataWidth +: NarrowDataWidth];
                out_req_o[i].q.strb  = in_wide_req_i[win].q.strb[i*StrbW +: StrbW];
            end
        end
        for (int w = 0; w < int'(NrWidePorts); w++) begin
            in_wide_rsp_o[w]         = '0;
            in_wide_rsp_o[w].q_ready = issue && (win == IdxW'(w));
            for (int i = 0; i < int'(NrPorts); i++) begin
                in_wide_rsp_o[w].p.data[i*NarrowDataWidth +: NarrowDataWidth] = out_rsp_i[i].p.data;
            end
        end
    end

    for (genvar i = 0; i < NrPorts; i++) begin : gen_starve
        assign narrow_valid[i] = in_narrow_req_i[i].q_valid;
        assign narrow_ready[i] = in_narrow_rsp_o[i].q_ready;

        mem_mux_starve_cnt #(
            .StarveLimit(StarveLimit)
        ) i_starve_cnt (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .narrow_valid_i(narrow_valid[i]),
            .narrow_ready_i(narrow_ready[i]),
            .wide_issue_i  (issue),
            .preempt_o     (preempt[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (issue) begin
            rr_q <= (win == IdxW'(NrWidePorts - 1)) ? '0 : win + 1'b1;
        end
    end

    // Tag pipeline: stage 0 captures the issue, last stage lines up with bank read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(MemoryLatency); k++) tag_q[k].valid <= 1'b0;
        end else begin
            tag_q[0] <= {issue, ~in_wide_req_i[win].q.write, MaxWideIdxW'(win)};
            for (int k = 1; k < int'(MemoryLatency); k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign tag_last = tag_q[MemoryLatency-1];

    always_comb begin
        for (int w = 0; w < int'(NrWidePorts); w++) begin
            wide_p_valid_o[w] = !rst_i && tag_last.valid && tag_last.rd &&
                                (tag_last.idx == MaxWideIdxW'(w));
        end
    end

endmodule

// File: tb/tb_mem_multi_wide_narrow_mux.sv
// Directed bench for mem_multi_wide_narrow_mux with 16 banks, 2 wide ports,
// two-cycle bank latency and a starvation limit of 3.
module tb_mem_multi_wide_narrow_mux;
    import mem_mux_pkg::*;

    localparam int NP = 16;
    localparam int NW = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    narrow_req_t narrow_req [NP];
    narrow_rsp_t narrow_rsp [NP];
    wide_req_t   wide_req   [NW];
    wide_rsp_t   wide_rsp   [NW];
    logic [NW-1:0] p_valid;
    narrow_req_t bank_req [NP];
    narrow_rsp_t bank_rsp [NP];
    logic [NP-1:0] bank_ready = '1;
    logic [DW-1:0] bank_d1 [NP];
    logic [DW-1:0] bank_d2 [NP];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_multi_wide_narrow_mux #(
        .NrWidePorts  (NW),
        .MemoryLatency(2),
        .StarveLimit  (3)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .in_narrow_req_i(narrow_req),
        .in_narrow_rsp_o(narrow_rsp),
        .in_wide_req_i  (wide_req),
        .in_wide_rsp_o  (wide_rsp),
        .wide_p_valid_o (p_valid),
        .out_req_o      (bank_req),
        .out_rsp_i      (bank_rsp)
    );

    // Bank model: accepted reads return {addr[15:0], bank index} two cycles later.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            bank_d1[i] <= (bank_req[i].q_valid && bank_ready[i] && !bank_req[i].q.write) ?
                          {bank_req[i].q.addr[15:0], 16'(i)} : 32'h0;
            bank_d2[i] <= bank_d1[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            bank_rsp[i].q_ready = bank_ready[i];
            bank_rsp[i].p.data  = bank_d2[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NP; i++) narrow_req[i] = '0;
        for (int w = 0; w < NW; w++) wide_req[w] = '0;
    endtask

    task automatic set_wide(input int w, input logic write, input logic [31:0] addr);
        wide_req[w] = '0;
        wide_req[w].q_valid = 1'b1;
        wide_req[w].q.write = write;
        wide_req[w].q.addr  = addr;
        for (int i = 0; i < NP; i++) begin
            wide_req[w].q.data[i*DW +: DW] = (w == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(i);
            wide_req[w].q.strb[i*4 +: 4]   = (w == 0) ? 4'(i) : ~4'(i);
        end
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        idle_inputs();
        bank_ready = '1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    function automatic logic [NP-1:0] out_valids();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = bank_req[i].q_valid;
        return v;
    endfunction

    function automatic logic [NP-1:0] narrow_readies();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = narrow_rsp[i].q_ready;
        return v;
    endfunction

    task automatic test_reset();
        logic [NP-1:0] v;
        step();
        rst_i = 1'b1;
        bank_ready = '1;
        for (int i = 0; i < NP; i++) begin
            narrow_req[i] = '0;
            narrow_req[i].q_valid = 1'b1;
            narrow_req[i].q.addr  = 32'h40 + 32'(i);
        end
        set_wide(0, 1'b1, 32'h100);
        set_wide(1, 1'b1, 32'h200);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            v = out_valids();
            tests_run++;
            if (v !== '0) begin
                tests_failed++;
                $display("FAIL reset_out_valid: got %h required 0", v);
            end
            v = narrow_readies();
            tests_run++;
            if (v !== '0 || {wide_rsp[1].q_ready, wide_rsp[0].q_ready} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_q_ready: narrow %h wide %b required 0", v,
                         {wide_rsp[1].q_ready, wide_rsp[0].q_ready});
            end
            tests_run++;
            if (p_valid !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_p_valid: got %b required 00", p_valid);
            end
            step();
        end
        rst_i = 1'b0;
        for (int i = 0; i < NP; i++) narrow_req[i].q_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({wide_rsp[1].q_ready, wide_rsp[0].q_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL release_first_w0: got %b required 01", {wide_rsp[1].q_ready, wide_rsp[0].q_ready});
        end
        step();
        @(negedge clk);
        tests_run++;
        if ({wide_rsp[1].q_ready, wide_rsp[0].q_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL release_rr_w1: got %b required 10", {wide_rsp[1].q_ready, wide_rsp[0].q_ready});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        narrow_q_t exp;
        int w;
        do_reset();
        set_wide(0, 1'b1, 32'h100);
        set_wide(1, 1'b1, 32'h200);
        for (int c = 0; c < 4; c++) begin
            w = c % 2;
            @(negedge clk);
            tests_run++;
            if ({wide_rsp[1].q_ready, wide_rsp[0].q_ready} !== (w == 0 ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL rr_grant c%0d: got %b required w%0d", c,
                         {wide_rsp[1].q_ready, wide_rsp[0].q_ready}, w);
            end
            for (int i = 0; i < NP; i++) begin
                exp = '0;
                exp.addr  = (w == 0) ? 32'h100 : 32'h200;
                exp.write = 1'b1;
                exp.amo   = AMONone;
                exp.data  = (w == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(i);
                exp.strb  = (w == 0) ? 4'(i) : ~4'(i);
                tests_run++;
                if (bank_req[i].q_valid !== 1'b1 || bank_req[i].q !== exp) begin
                    tests_failed++;
                    $display("FAIL rr_slice c%0d bank%0d: got v%b addr %h data %h strb %h required addr %h data %h strb %h",
                             c, i, bank_req[i].q_valid, bank_req[i].q.addr, bank_req[i].q.data,
                             bank_req[i].q.strb, exp.addr, exp.data, exp.strb);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_delayed_grant();
        logic [NP-1:0] v;
        do_reset();
        set_wide(0, 1'b1, 32'h500);
        bank_ready[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v = out_valids();
            tests_run++;
            if (v !== '0 || wide_rsp[0].q_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL delayed_hold c%0d: valids %h ready %b required 0 0", c, v, wide_rsp[0].q_ready);
            end
            step();
        end
        bank_ready[3] = 1'b1;
        @(negedge clk);
        v = out_valids();
        tests_run++;
        if (v !== '1 || wide_rsp[0].q_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL delayed_issue: valids %h ready %b required ffff 1", v, wide_rsp[0].q_ready);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_wide;
        do_reset();
        set_wide(0, 1'b1, 32'h600);
        narrow_req[0] = '0;
        narrow_req[0].q_valid = 1'b1;
        narrow_req[0].q.write = 1'b1;
        narrow_req[0].q.addr  = 32'h40;
        narrow_req[0].q.data  = 32'hCAFE;
        for (int c = 0; c < 8; c++) begin
            exp_wide = (c % 4) != 3;
            @(negedge clk);
            tests_run++;
            if (wide_rsp[0].q_ready !== exp_wide || narrow_rsp[0].q_ready !== !exp_wide) begin
                tests_failed++;
                $display("FAIL starve_grant c%0d: wide %b narrow %b required wide %b", c,
                         wide_rsp[0].q_ready, narrow_rsp[0].q_ready, exp_wide);
            end
            tests_run++;
            if (bank_req[0].q.addr !== (exp_wide ? 32'h600 : 32'h40)) begin
                tests_failed++;
                $display("FAIL starve_addr c%0d: got %h required %h", c, bank_req[0].q.addr,
                         exp_wide ? 32'h600 : 32'h40);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_read_latency();
        logic [WideDataW-1:0] exp;
        do_reset();
        set_wide(1, 1'b0, 32'h300);
        @(negedge clk);
        tests_run++;
        if (wide_rsp[1].q_ready !== 1'b1 || p_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_issue: ready %b p_valid %b required 1 00", wide_rsp[1].q_ready, p_valid);
        end
        step();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (p_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_t1: got %b required 00", p_valid);
        end
        step();
        @(negedge clk);
        for (int i = 0; i < NP; i++) exp[i*DW +: DW] = {16'h0300, 16'(i)};
        tests_run++;
        if (p_valid !== 2'b10) begin
            tests_failed++;
            $display("FAIL rd_t2_valid: got %b required 10", p_valid);
        end
        tests_run++;
        if (wide_rsp[1].p.data !== exp || wide_rsp[0].p.data !== exp) begin
            tests_failed++;
            $display("FAIL rd_data: got %h required %h", wide_rsp[1].p.data, exp);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (p_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_t3: got %b required 00", p_valid);
        end
        step();
        set_wide(1, 1'b1, 32'h310);
        @(negedge clk);
        tests_run++;
        if (wide_rsp[1].q_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_issue: got %b required 1", wide_rsp[1].q_ready);
        end
        step();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (p_valid !== 2'b00) begin
                tests_failed++;
                $display("FAIL wr_no_p_valid t%0d: got %b required 00", c, p_valid);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_wide(0, 1'b0, 32'h700);
        @(negedge clk);
        tests_run++;
        if (wide_rsp[0].q_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_issue: got %b required 1", wide_rsp[0].q_ready);
        end
        step();
        idle_inputs();
        rst_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (p_valid !== 2'b00) begin
                tests_failed++;
                $display("FAIL midrst_p_valid t%0d: got %b required 00", c, p_valid);
            end
            step();
            rst_i = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [WideDataW-1:0] exp;
        do_reset();
        set_wide(0, 1'b0, 32'h800);
        set_wide(1, 1'b0, 32'h900);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if ({wide_rsp[1].q_ready, wide_rsp[0].q_ready} !== (c == 0 ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL b2b_grant c%0d: got %b", c, {wide_rsp[1].q_ready, wide_rsp[0].q_ready});
            end
            step();
        end
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) exp[i*DW +: DW] = {(c == 0 ? 16'h0800 : 16'h0900), 16'(i)};
            tests_run++;
            if (p_valid !== (c == 0 ? 2'b01 : 2'b10) || wide_rsp[c].p.data !== exp) begin
                tests_failed++;
                $display("FAIL b2b_read w%0d: p_valid %b data %h required data %h", c, p_valid,
                         wide_rsp[c].p.data, exp);
            end
            step();
        end
        @(negedge clk);
        tests_run++;
        if (p_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_tail: got %b required 00", p_valid);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_delayed_grant();
        test_starvation();
        test_read_latency();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
